// File: rtl/lane_swizzle_fifo_if.sv
// Handshake bundle for lane_swizzle_fifo: producer side (in_*) and consumer side (out_*).
// The master modport is the environment; the slave modport is the swizzle block.
interface lane_swizzle_fifo_if #(
   parameter int W = 32
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic [1:0]   in_mode;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;

   modport master (
      output in_valid, in_data, in_mode, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, in_mode, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/lane_swizzle_fifo.sv
// Per-word lane/bit permutation (pass, half-lane swap, lane reverse, bit reverse)
// feeding an output queue behind valid/ready; xfer_cnt counts completed pops.
module lane_swizzle_fifo #(
   parameter int NLANES     = 4,
   parameter int LANE_W     = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              flush,
   lane_swizzle_fifo_if.slave                bus,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   count,
   output logic [31:0]                       xfer_cnt
);
   localparam int W    = NLANES * LANE_W;
   localparam int HW   = LANE_W / 2;
   localparam int CW   = $clog2(FIFO_DEPTH + 1);
   localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   logic [W-1:0]  swap_w;
   logic [W-1:0]  lrev_w;
   logic [W-1:0]  brev_w;
   logic [W-1:0]  xform_w;

   logic [W-1:0]  mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [CW-1:0] count_reg;
   logic [31:0]   xfer_cnt_reg;

   logic          push;
   logic          pop;
   logic          not_empty;

   genvar gi;
   generate
      for (gi = 0; gi < NLANES; gi++) begin : g_lane
         assign swap_w[gi*LANE_W +: LANE_W] = {bus.in_data[gi*LANE_W +: HW],
                                               bus.in_data[gi*LANE_W + HW +: HW]};
         assign lrev_w[gi*LANE_W +: LANE_W] = bus.in_data[(NLANES-1-gi)*LANE_W +: LANE_W];
      end
      for (gi = 0; gi < W; gi++) begin : g_bit
         assign brev_w[gi] = bus.in_data[W-1-gi];
      end
   endgenerate

   always_comb begin
      xform_w = bus.in_data;
      case (bus.in_mode)
         2'd1:    xform_w = swap_w;
         2'd2:    xform_w = lrev_w;
         2'd3:    xform_w = brev_w;
         default: xform_w = bus.in_data;
      endcase
   end

   // Full queue refuses input even if the head is leaving this cycle.
   assign not_empty    = (count_reg != '0);
   assign bus.in_ready = !rst && !flush && (count_reg < CW'(FIFO_DEPTH));
   assign bus.out_valid = not_empty;
   assign bus.out_data  = not_empty ? mem[rd_ptr_reg] : '0;
   assign push = bus.in_valid && bus.in_ready;
   assign pop  = not_empty && bus.out_ready && !flush;
   assign count    = count_reg;
   assign xfer_cnt = xfer_cnt_reg;

   // Storage carries no reset; unwritten entries are never visible because out_data is gated.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg] <= xform_w;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         xfer_cnt_reg <= '0;
      end else if (flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop) begin
            rd_ptr_reg   <= rd_ptr_reg + 1'b1;
            xfer_cnt_reg <= xfer_cnt_reg + 32'd1;
         end
         if (push && !pop) begin
            count_reg <= count_reg + 1'b1;
         end else if (pop && !push) begin
            count_reg <= count_reg - 1'b1;
         end
      end
   end
endmodule
